// File: rtl/alu_mul_seq_pkg.sv
// Shared constants for the sequential shift-add multiplier: operand width,
// ALU op codes understood by the external ALU, and the FSM state encoding.
package alu_mul_seq_pkg;

    localparam int MUL_DATA_WIDTH = 32;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/alu_mul_seq.sv
// Multi-cycle unsigned multiplier driving an external ALU with one ADD per cycle
// in a shift-add loop; product is presented on a valid/ready response port.
module alu_mul_seq
    import alu_mul_seq_pkg::*;
#(
    parameter int         DATA_WIDTH = MUL_DATA_WIDTH,
    parameter logic [2:0] ALUOP_ADD  = OP_ADD
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DATA_WIDTH-1:0] req_a,
    input  logic [DATA_WIDTH-1:0] req_b,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_hi,
    output logic [DATA_WIDTH-1:0] resp_lo,
    output logic [DATA_WIDTH-1:0] alu_A,
    output logic [DATA_WIDTH-1:0] alu_B,
    output logic [2:0]            alu_op,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_carryout
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    logic [1:0]            state_reg;
    logic [CNT_W-1:0]      cnt_reg;
    logic [DATA_WIDTH-1:0] mcand_reg;
    logic [DATA_WIDTH-1:0] p_hi_reg;
    logic [DATA_WIDTH-1:0] p_lo_reg;
    logic [DATA_WIDTH-1:0] res_hi_reg;
    logic [DATA_WIDTH-1:0] res_lo_reg;

    logic                  calc;
    logic [DATA_WIDTH-1:0] p_hi_next;
    logic [DATA_WIDTH-1:0] p_lo_next;

    assign calc       = (state_reg == ST_CALC);
    assign req_ready  = (state_reg == ST_IDLE);
    assign resp_valid = (state_reg == ST_DONE);
    assign resp_hi    = res_hi_reg;
    assign resp_lo    = res_lo_reg;

    // ALU operands are forced to zero outside CALC so the shared ALU sees a quiet bus.
    assign alu_op = ALUOP_ADD;
    assign alu_A  = calc ? p_hi_reg : '0;

    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_alu_b
            assign alu_B[gi] = mcand_reg[gi] & p_lo_reg[0] & calc;
        end
    endgenerate

    // Partial sum plus carry shifts right by one, consuming one multiplier bit.
    assign {p_hi_next, p_lo_next} = {alu_carryout, alu_result, p_lo_reg[DATA_WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            mcand_reg  <= '0;
            p_hi_reg   <= '0;
            p_lo_reg   <= '0;
            res_hi_reg <= '0;
            res_lo_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid) begin
                        mcand_reg <= req_a;
                        p_hi_reg  <= '0;
                        p_lo_reg  <= req_b;
                        cnt_reg   <= '0;
                        state_reg <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    p_hi_reg <= p_hi_next;
                    p_lo_reg <= p_lo_next;
                    cnt_reg  <= cnt_reg + 1'b1;
                    if (cnt_reg == CNT_LAST) begin
                        res_hi_reg <= p_hi_next;
                        res_lo_reg <= p_lo_next;
                        state_reg  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (resp_ready) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: behavioural 32-bit ALU on the alu_* port, randomized
// requests, and a queue-based scoreboard checked by an independent monitor.
module tb_alu_mul_seq;

    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [W-1:0]  req_a;
    logic [W-1:0]  req_b;
    logic          resp_valid;
    logic          resp_ready;
    logic [W-1:0]  resp_hi;
    logic [W-1:0]  resp_lo;
    logic [W-1:0]  alu_A;
    logic [W-1:0]  alu_B;
    logic [2:0]    alu_op;
    logic [W-1:0]  alu_result;
    logic          alu_carryout;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_hs = -1;
    bit rand_ready = 1'b0;

    typedef struct {
        logic [2*W-1:0] prod;
        int             acc;
    } exp_t;
    exp_t q[$];

    alu_mul_seq dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_hi      (resp_hi),
        .resp_lo      (resp_lo),
        .alu_A        (alu_A),
        .alu_B        (alu_B),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .alu_carryout (alu_carryout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // The team's 32-bit ALU, modelled behaviourally.
    always_comb begin
        alu_result   = '0;
        alu_carryout = 1'b0;
        case (alu_op)
            3'b000: alu_result = alu_A & alu_B;
            3'b001: alu_result = alu_A | alu_B;
            3'b010: {alu_carryout, alu_result} = {1'b0, alu_A} + {1'b0, alu_B};
            3'b110: {alu_carryout, alu_result} = {1'b0, alu_A} - {1'b0, alu_B};
            3'b111: alu_result = W'($signed(alu_A) < $signed(alu_B));
            default: alu_result = '0;
        endcase
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) resp_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: latency, stability, idle-bus and product checks against the queue.
    bit            pend = 1'b0;
    logic [2*W-1:0] held;
    always @(negedge clk) begin
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (req_ready || resp_valid) begin
                checks++;
                if (alu_A != 0 || alu_B != 0 || alu_op != 3'b010) begin
                    errors++;
                    $display("FAIL idle_alu cyc=%0d got A=%h B=%h op=%b want 0/0/010", cyc, alu_A, alu_B, alu_op);
                end
            end
            if (resp_valid) begin
                checks++;
                if (req_ready) begin
                    errors++;
                    $display("FAIL busy_ready cyc=%0d req_ready=1 while resp_valid, want 0", cyc);
                end
                checks++;
                if (!pend) begin
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_resp cyc=%0d got %h_%h with empty queue", cyc, resp_hi, resp_lo);
                    end else if (cyc - q[0].acc != LAT) begin
                        errors++;
                        $display("FAIL latency cyc=%0d got %0d want %0d", cyc, cyc - q[0].acc, LAT);
                    end
                end else if ({resp_hi, resp_lo} != held) begin
                    errors++;
                    $display("FAIL resp_stable cyc=%0d got %h want %h", cyc, {resp_hi, resp_lo}, held);
                end
                held = {resp_hi, resp_lo};
                if (resp_ready && q.size() != 0) begin
                    exp_t e;
                    e = q.pop_front();
                    checks++;
                    if ({resp_hi, resp_lo} != e.prod) begin
                        errors++;
                        $display("FAIL product cyc=%0d got %h_%h want %h_%h", cyc, resp_hi, resp_lo, e.prod[2*W-1:W], e.prod[W-1:0]);
                    end else begin
                        $display("resp cyc=%0d product %h_%h ok", cyc, resp_hi, resp_lo);
                    end
                    last_hs = cyc;
                end
            end
            pend = resp_valid && !resp_ready;
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, output int acc);
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        acc       = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (req_ready) begin
                acc = cyc;
                q.push_back('{prod: (2*W)'(a) * (2*W)'(b), acc: cyc});
                break;
            end
        end
        checks++;
        if (acc < 0) begin
            errors++;
            $display("FAIL req_accept got no req_ready for %h x %h within budget", a, b);
        end else begin
            $display("req cyc=%0d %h x %h accepted", acc, a, b);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (q.size() == 0) break;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d outstanding want 0", q.size());
        end
    endtask

    task automatic check_reset_state(input string tag);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_hi !== '0 || resp_lo !== '0) begin
            errors++;
            $display("FAIL %s got rdy=%b vld=%b hi=%h lo=%h want 1/0/0/0", tag, req_ready, resp_valid, resp_hi, resp_lo);
        end else begin
            $display("%s state ok", tag);
        end
    endtask

    initial begin
        int acc;
        int hs1;
        logic [W-1:0] a;
        logic [W-1:0] b;

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_state("reset");

        send(32'd3, 32'd5, acc);
        wait_drain(100);
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, acc);
        wait_drain(100);

        // Zero multiplicand: ALU operand B must stay zero every busy cycle.
        send(32'h0, 32'h1234_5678, acc);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            if (!req_ready && !resp_valid) begin
                checks++;
                if (alu_B != 0) begin
                    errors++;
                    $display("FAIL zero_alu_b cyc=%0d got %h want 0", cyc, alu_B);
                end
            end
        end
        wait_drain(100);

        // Consumer stalls for 10 cycles with the product pending.
        resp_ready = 1'b0;
        send(32'h8000_0000, 32'h2, acc);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (resp_valid) break;
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (!resp_valid || req_ready || resp_hi != 32'h1 || resp_lo != 32'h0) begin
                errors++;
                $display("FAIL stall_hold got vld=%b rdy=%b %h_%h want 1/0/00000001_00000000", resp_valid, req_ready, resp_hi, resp_lo);
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        wait_drain(100);

        // Back-to-back: second accept must follow the first handshake directly.
        send(32'd7, 32'd6, acc);
        send(32'h0001_0000, 32'h0001_0000, acc);
        hs1 = last_hs;
        checks++;
        if (acc != hs1 + 1) begin
            errors++;
            $display("FAIL b2b_accept got cycle %0d want %0d", acc, hs1 + 1);
        end
        wait_drain(100);

        // Reset during CALC iteration 10 aborts the product.
        send(32'hDEAD_BEEF, 32'h0BAD_F00D, acc);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        check_reset_state("mid_calc_reset");
        repeat (40) begin
            @(negedge clk);
            checks++;
            if (resp_valid) begin
                errors++;
                $display("FAIL aborted_resp cyc=%0d got resp_valid=1 want 0", cyc);
            end
        end

        rand_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            a = $urandom;
            b = $urandom;
            case (i % 8)
                0: a = '1;
                1: b = '0;
                2: b = 32'h1;
                default: ;
            endcase
            send(a, b, acc);
        end
        wait_drain(2000);
        rand_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
